// File: rtl/udp_resp_pkg.sv
// udp_resp_pkg: shared FSM encoding, reply type codes, payload lengths and status bits (lengths grow under UDP_RESP_CSUM_EN)
package udp_resp_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, START, SEND, WAIT_DONE} state_t;
  localparam logic [7:0] TYPE_VER = 8'h01;
  localparam logic [7:0] TYPE_ACK = 8'h02;
`ifdef UDP_RESP_CSUM_EN
  localparam logic [15:0] LEN_VER = 16'd10;
  localparam logic [15:0] LEN_ACK = 16'd14;
`else
  localparam logic [15:0] LEN_VER = 16'd8;
  localparam logic [15:0] LEN_ACK = 16'd12;
`endif
  localparam int FRAME_MAX = 14;
  localparam int ST_LAST = 0;
  localparam int ST_OVF = 1;
endpackage

// File: rtl/udp_resp_bytesel.sv
// udp_resp_bytesel: combinational reply byte mux; with UDP_RESP_CSUM_EN it also sums the payload into a trailing checksum
module udp_resp_bytesel
  import udp_resp_pkg::*;
#(
  parameter logic [31:0] VERSION = 32'h0000_0001,
  parameter logic [15:0] MAGIC = 16'h55AA
) (
  input  logic        is_ack,
  input  logic [7:0]  seq,
  input  logic [15:0] pkg_num,
  input  logic [15:0] pkg_total,
  input  logic [15:0] byte_num,
  input  logic [7:0]  status,
  input  logic [4:0]  idx,
  output logic [7:0]  data
);
  logic [7:0] b [FRAME_MAX];
`ifdef UDP_RESP_CSUM_EN
  logic [15:0] csum;
`endif
  always_comb begin
    for (int i = 0; i < FRAME_MAX; i++) b[i] = '0;
    b[0] = MAGIC[15:8];
    b[1] = MAGIC[7:0];
    b[2] = is_ack ? TYPE_ACK : TYPE_VER;
    b[3] = seq;
    b[4] = is_ack ? pkg_num[15:8] : VERSION[31:24];
    b[5] = is_ack ? pkg_num[7:0] : VERSION[23:16];
    b[6] = is_ack ? pkg_total[15:8] : VERSION[15:8];
    b[7] = is_ack ? pkg_total[7:0] : VERSION[7:0];
    b[8] = is_ack ? byte_num[15:8] : 8'h00;
    b[9] = is_ack ? byte_num[7:0] : 8'h00;
    b[10] = is_ack ? status : 8'h00;
`ifdef UDP_RESP_CSUM_EN
    csum = '0;
    // unused tail bytes are still zero here, so summing the full window is exact
    for (int i = 0; i < FRAME_MAX - 2; i++) csum = csum + 16'(b[i]);
    if (is_ack) begin
      b[12] = csum[15:8];
      b[13] = csum[7:0];
    end else begin
      b[8] = csum[15:8];
      b[9] = csum[7:0];
    end
`endif
    data = (idx < 5'(FRAME_MAX)) ? b[idx[3:0]] : '0;
  end
endmodule

// File: rtl/udp_cmd_resp.sv
// udp_cmd_resp: turns version-read / config-done events into UDP reply frames; UDP_RESP_CSUM_EN appends a 16-bit checksum
module udp_cmd_resp
  import udp_resp_pkg::*;
#(
  parameter logic [31:0] VERSION = 32'h0000_0001,
  parameter logic [15:0] MAGIC = 16'h55AA,
  parameter logic [19:0] TIMEOUT_CYC = 20'd1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        comm_reset_i,
  input  logic        rd_version_i,
  input  logic        cfg_done_i,
  input  logic [15:0] cfg_pkg_num_i,
  input  logic [15:0] cfg_pkg_total_i,
  input  logic [15:0] cfg_byte_num_i,
  input  logic        tx_req,
  input  logic        tx_done,
  output logic        tx_start_en,
  output logic [15:0] tx_byte_num,
  output logic [7:0]  tx_data,
  output logic        busy_o,
  output logic        timeout_o
);
  state_t state, state_n;
  logic pend_ver, pend_ack, ovf;
  logic [15:0] info_num, info_total, info_bytes;
  logic sh_ack;
  logic [15:0] sh_num, sh_total, sh_bytes;
  logic [7:0] sh_status, ack_status, seq, byte_sel;
  logic [4:0] idx;
  logic [19:0] tmo_cnt;
  logic is_load, active, tmo_hit, done_hit, clr_ack, clr_ver;
  assign is_load = state == LOAD;
  assign active = state == START || state == SEND || state == WAIT_DONE;
  assign tmo_hit = active && tmo_cnt == TIMEOUT_CYC - 20'd1;
  assign done_hit = (state == SEND || state == WAIT_DONE) && tx_done;
  assign clr_ack = is_load && pend_ack;
  assign clr_ver = is_load && !pend_ack;
  assign busy_o = state != IDLE;
  always_comb begin
    ack_status = '0;
    ack_status[ST_LAST] = (info_num + 16'd1) == info_total;
    ack_status[ST_OVF] = ovf;
  end
  udp_resp_bytesel #(.VERSION(VERSION), .MAGIC(MAGIC)) u_bytesel (
    .is_ack(sh_ack),
    .seq(seq),
    .pkg_num(sh_num),
    .pkg_total(sh_total),
    .byte_num(sh_bytes),
    .status(sh_status),
    .idx(is_load ? 5'd0 : idx),
    .data(byte_sel)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = (pend_ack || pend_ver) ? LOAD : IDLE;
      LOAD: state_n = START;
      START: state_n = SEND;
      SEND: state_n = (idx >= tx_byte_num[4:0]) ? WAIT_DONE : SEND;
      default: state_n = state;
    endcase
    if (done_hit || tmo_hit) state_n = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= comm_reset_i ? IDLE : state_n;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_ver <= 1'b0;
      pend_ack <= 1'b0;
      ovf <= 1'b0;
      info_num <= '0;
      info_total <= '0;
      info_bytes <= '0;
      sh_ack <= 1'b0;
      sh_num <= '0;
      sh_total <= '0;
      sh_bytes <= '0;
      sh_status <= '0;
      seq <= '0;
      idx <= '0;
      tmo_cnt <= '0;
      tx_start_en <= 1'b0;
      tx_byte_num <= '0;
      tx_data <= '0;
      timeout_o <= 1'b0;
    end else if (comm_reset_i) begin
      pend_ver <= 1'b0;
      pend_ack <= 1'b0;
      ovf <= 1'b0;
      seq <= '0;
      timeout_o <= 1'b0;
      tx_start_en <= 1'b0;
    end else begin
      pend_ver <= rd_version_i | (pend_ver & ~clr_ver);
      pend_ack <= cfg_done_i | (pend_ack & ~clr_ack);
      // an overwrite only counts against info that has not been taken yet
      ovf <= (cfg_done_i & pend_ack & ~clr_ack) | (ovf & ~clr_ack);
      if (cfg_done_i) begin
        info_num <= cfg_pkg_num_i;
        info_total <= cfg_pkg_total_i;
        info_bytes <= cfg_byte_num_i;
      end
      tx_start_en <= is_load;
      if (is_load) begin
        sh_ack <= pend_ack;
        sh_num <= info_num;
        sh_total <= info_total;
        sh_bytes <= info_bytes;
        sh_status <= ack_status;
        tx_byte_num <= pend_ack ? LEN_ACK : LEN_VER;
        tx_data <= byte_sel;
        idx <= 5'd1;
        tmo_cnt <= '0;
      end
      if (state == SEND && tx_req && idx < tx_byte_num[4:0]) begin
        tx_data <= byte_sel;
        idx <= idx + 5'd1;
      end
      if (active) tmo_cnt <= tmo_cnt + 20'd1;
      if (tmo_hit && !done_hit) timeout_o <= 1'b1;
      if (done_hit) seq <= seq + 8'd1;
    end
  end
endmodule

// File: tb/tb_udp_cmd_resp.sv
// tb_udp_cmd_resp: directed stimulus against a frame-level reply model, plus literal frame checks
module tb_udp_cmd_resp;
  localparam logic [31:0] VER = 32'h0000_0001;
  localparam logic [15:0] MAG = 16'h55AA;
  localparam int TMO = 100;
`ifdef UDP_RESP_CSUM_EN
  localparam int LV = 10, LA = 14;
`else
  localparam int LV = 8, LA = 12;
`endif
  logic clk = 0, rst_n = 0, comm_reset_i = 0, rd_version_i = 0, cfg_done_i = 0, tx_req = 0, tx_done = 0;
  logic [15:0] cfg_pkg_num_i = 0, cfg_pkg_total_i = 0, cfg_byte_num_i = 0;
  logic tx_start_en, busy_o, timeout_o;
  logic [15:0] tx_byte_num;
  logic [7:0] tx_data;
  always #5 clk = ~clk;
  udp_cmd_resp #(.VERSION(VER), .MAGIC(MAG), .TIMEOUT_CYC(20'd100)) dut (
    .clk(clk), .rst_n(rst_n), .comm_reset_i(comm_reset_i), .rd_version_i(rd_version_i),
    .cfg_done_i(cfg_done_i), .cfg_pkg_num_i(cfg_pkg_num_i), .cfg_pkg_total_i(cfg_pkg_total_i),
    .cfg_byte_num_i(cfg_byte_num_i), .tx_req(tx_req), .tx_done(tx_done), .tx_start_en(tx_start_en),
    .tx_byte_num(tx_byte_num), .tx_data(tx_data), .busy_o(busy_o), .timeout_o(timeout_o)
  );
  int n_cmp = 0, n_bad = 0;
  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endfunction
  bit m_pv, m_pa, m_ovf, m_tmo, in_frame, req_prev;
  logic [15:0] m_num, m_tot, m_byt;
  logic [7:0] m_seq;
  logic [7:0] ef [16];
  logic [7:0] cap [16];
  int elen, ptr, cyc, starts;
  function automatic void build(bit ack);
    logic [15:0] s;
    for (int i = 0; i < 16; i++) ef[i] = 8'h00;
    ef[0] = MAG[15:8];
    ef[1] = MAG[7:0];
    ef[2] = ack ? 8'h02 : 8'h01;
    ef[3] = m_seq;
    if (ack) begin
      ef[4] = m_num[15:8]; ef[5] = m_num[7:0];
      ef[6] = m_tot[15:8]; ef[7] = m_tot[7:0];
      ef[8] = m_byt[15:8]; ef[9] = m_byt[7:0];
      ef[10] = {6'd0, m_ovf, (m_num + 16'd1) == m_tot};
      elen = LA;
    end else begin
      ef[4] = VER[31:24]; ef[5] = VER[23:16]; ef[6] = VER[15:8]; ef[7] = VER[7:0];
      elen = LV;
    end
    s = 0;
    for (int i = 0; i < elen - 2; i++) s += 16'(ef[i]);
`ifdef UDP_RESP_CSUM_EN
    ef[elen-2] = s[15:8];
    ef[elen-1] = s[7:0];
`endif
  endfunction
  always @(negedge clk) begin
    if (!rst_n) begin
      m_pv = 0; m_pa = 0; m_ovf = 0; m_tmo = 0; in_frame = 0; req_prev = 0; m_seq = 0;
    end else begin
      if (in_frame) cyc++;
      if (in_frame && cyc >= TMO) begin m_tmo = 1; in_frame = 0; end
      if (tx_start_en) begin
        starts++;
        check("start_pending", 32'(m_pa | m_pv), 1);
        if (m_pa || m_pv) begin
          if (m_pa) begin build(1); m_pa = 0; m_ovf = 0; end
          else begin build(0); m_pv = 0; end
          check("byte_num", 32'(tx_byte_num), elen);
          check("byte0", 32'(tx_data), 32'(ef[0]));
          cap[0] = tx_data; ptr = 1; in_frame = 1; cyc = 0;
        end
      end else if (in_frame && req_prev) begin
        check($sformatf("byte%0d", ptr), 32'(tx_data), 32'(ef[ptr < elen ? ptr : elen - 1]));
        if (ptr < elen) cap[ptr] = tx_data;
        ptr++;
      end
      check("timeout_o", 32'(timeout_o), 32'(m_tmo));
      req_prev = tx_req;
      if (comm_reset_i) begin
        m_pv = 0; m_pa = 0; m_ovf = 0; m_seq = 0; m_tmo = 0; in_frame = 0;
      end else begin
        if (tx_done && in_frame) begin m_seq++; in_frame = 0; end
        if (rd_version_i) m_pv = 1;
        if (cfg_done_i) begin
          if (m_pa) m_ovf = 1;
          m_pa = 1; m_num = cfg_pkg_num_i; m_tot = cfg_pkg_total_i; m_byt = cfg_byte_num_i;
        end
      end
    end
  end
  task automatic drive(input bit req, done, ver, cfg, crst, input logic [15:0] n, t, b);
    tx_req = req; tx_done = done; rd_version_i = ver; cfg_done_i = cfg; comm_reset_i = crst;
    cfg_pkg_num_i = n; cfg_pkg_total_i = t; cfg_byte_num_i = b;
    @(posedge clk); #1;
    tx_req = 0; tx_done = 0; rd_version_i = 0; cfg_done_i = 0; comm_reset_i = 0;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic wait_start();
    for (int k = 0; k < 20 && !tx_start_en; k++) idle(1);
    check("start_seen", 32'(tx_start_en), 1);
  endtask
  task automatic serve(input int nreq);
    wait_start();
    idle(1);
    for (int i = 0; i < nreq; i++) drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    idle(2);
  endtask
  logic [7:0] lit_ver [8] = '{8'h55, 8'hAA, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
  logic [7:0] lit_ack [12] = '{8'h55, 8'hAA, 8'h02, 8'h00, 8'h00, 8'h09, 8'h00, 8'h0A, 8'h04, 8'h00, 8'h01, 8'h00};
  int s0;
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_start", 32'(tx_start_en), 0);
    check("rst_len", 32'(tx_byte_num), 0);
    check("rst_data", 32'(tx_data), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_tmo", 32'(timeout_o), 0);
    rst_n = 1;
    idle(2);
    // version reply
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    serve(LV);
    for (int i = 0; i < 8; i++) check($sformatf("ver_lit%0d", i), 32'(cap[i]), 32'(lit_ver[i]));
`ifdef UDP_RESP_CSUM_EN
    check("ver_csum_hi", 32'(cap[8]), 32'h01);
    check("ver_csum_lo", 32'(cap[9]), 32'h01);
`endif
    check("ver_busy_drop", 32'(busy_o), 0);
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    serve(LV);
    check("ver2_seq", 32'(cap[3]), 32'h01);
    // config ack from a clean sequence
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 16'h0009, 16'h000A, 16'h0400);
    serve(LA);
    for (int i = 0; i < 12; i++) check($sformatf("ack_lit%0d", i), 32'(cap[i]), 32'(lit_ack[i]));
    // collision: ack wins, version follows
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 1, 0, 16'h0001, 16'h0002, 16'h0010);
    serve(LA);
    check("col1_type", 32'(cap[2]), 32'h02);
    check("col1_seq", 32'(cap[3]), 32'h00);
    check("col1_status", 32'(cap[10]), 32'h01);
    serve(LV);
    check("col2_type", 32'(cap[2]), 32'h01);
    check("col2_seq", 32'(cap[3]), 32'h01);
    // overwrite while a version reply is sending
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    wait_start();
    idle(1);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 16'h0003, 16'h0010, 16'h0020);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 16'h0004, 16'h0010, 16'h0030);
    for (int i = 0; i < LV - 4; i++) drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    serve(LA);
    check("ovw_num", 32'(cap[5]), 32'h04);
    check("ovw_bytes", 32'(cap[9]), 32'h30);
    check("ovw_status", 32'(cap[10]), 32'h02);
    s0 = starts;
    idle(10);
    check("ovw_single_ack", starts, s0);
    // timeout: no tx_done ever
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    wait_start();
    idle(TMO + 5);
    check("tmo_set", 32'(timeout_o), 1);
    check("tmo_idle", 32'(busy_o), 0);
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    serve(LV);
    check("tmo_seq_kept", 32'(cap[3]), 32'h00);
    check("tmo_sticky", 32'(timeout_o), 1);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    check("tmo_cleared", 32'(timeout_o), 0);
    // abort mid-SEND with another version pending
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    wait_start();
    idle(1);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    check("abort_idle", 32'(busy_o), 0);
    check("abort_start", 32'(tx_start_en), 0);
    s0 = starts;
    idle(20);
    check("abort_no_start", starts, s0);
    // async reset mid-frame
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    wait_start();
    idle(1);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 0;
    #1;
    check("arst_data", 32'(tx_data), 0);
    check("arst_len", 32'(tx_byte_num), 0);
    check("arst_busy", 32'(busy_o), 0);
    @(posedge clk); #1 rst_n = 1;
    idle(3);
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    serve(LV);
    check("arst_seq", 32'(cap[3]), 32'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
